// File: rtl/text_console_pkg.sv
// Shared definitions for the text console writer: geometry defaults, control codes, states.
package text_console_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 60;
  localparam int ADDR_W   = 13;
  localparam int X_W      = 7;
  localparam int Y_W      = 6;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_DEL   = 8'h7F;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RELEASE, S_CLEAR} state_t;

  typedef enum logic [2:0] {CUR_NONE, CUR_ADV, CUR_NL, CUR_CR, CUR_BS, CUR_HOME} cur_cmd_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_SPACE) && (c != CH_DEL);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor: x/y registers updated by one command per cycle; cell address y*COLS+x is combinational.
// Commands take effect on the next clock edge; no backpressure.
module text_cursor
  import text_console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  cur_cmd_t          cmd,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  logic [Y_W-1:0] y_inc;

  // No scrolling: the row index simply wraps to the top of the screen.
  assign y_inc = (y == Y_LAST) ? '0 : y + 1'b1;
  assign addr  = ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else begin
      case (cmd)
        CUR_ADV: begin
          if (x == X_LAST) begin
            x <= '0;
            y <= y_inc;
          end else begin
            x <= x + 1'b1;
          end
        end
        CUR_NL: begin
          x <= '0;
          y <= y_inc;
        end
        CUR_CR: x <= '0;
        CUR_BS: begin
          if (x != '0) begin
            x <= x - 1'b1;
          end else if (y != '0) begin
            x <= X_LAST;
            y <= y - 1'b1;
          end
        end
        CUR_HOME: begin
          x <= '0;
          y <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte stream to character-buffer writes; one STB/ACK write per cell, 5 cycles accept-to-ready with a registered ACK.
// char_ready drops for the whole write handshake and for the full-screen clear; a missing ACK times out and sets err.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int         COLS           = COLS_DEF,
  parameter int         ROWS           = ROWS_DEF,
  parameter logic [7:0] ATTR           = 8'h00,
  parameter int         ACK_TIMEOUT    = 64,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           char_valid,
  input  logic [7:0]     char_data,
  output logic           char_ready,
  input  logic           clear_req,
  output logic           busy,
  output logic           err,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y,
  output logic           STB,
  output logic [31:0]    ADDR,
  output logic [31:0]    DAT_O,
  input  logic           ACK
);

  localparam int                  TMO_W       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]   LAST_CELL   = ADDR_W'(COLS * ROWS - 1);
  localparam state_t              RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t              state_q, state_d;
  logic                stb_q, stb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         dat_q, dat_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                clearing_q, clearing_d;
  logic                adv_q, adv_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;

  cur_cmd_t            cur_cmd;
  logic [ADDR_W-1:0]   cur_addr;
  logic                do_launch;
  logic [ADDR_W-1:0]   launch_addr;
  logic [7:0]          launch_chr;
  logic                timeout;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk   (clk),
    .reset (reset),
    .cmd   (cur_cmd),
    .x     (cursor_x),
    .y     (cursor_y),
    .addr  (cur_addr)
  );

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    clearing_d  = clearing_q;
    adv_d       = adv_q;
    clr_d       = clr_q;
    cur_cmd     = CUR_NONE;
    do_launch   = 1'b0;
    launch_addr = '0;
    launch_chr  = CH_SPACE;
    timeout     = 1'b0;
    // ACK gating keeps a fresh STB from overlapping a stale acknowledge.
    char_ready  = (state_q == S_IDLE) && !clear_req && !ACK;

    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          clr_d      = '0;
          err_d      = 1'b0;
          clearing_d = 1'b1;
        end else if (char_valid && char_ready) begin
          if (char_data == CH_LF) begin
            cur_cmd = CUR_NL;
          end else if (char_data == CH_CR) begin
            cur_cmd = CUR_CR;
          end else if (char_data == CH_FF) begin
            state_d    = S_CLEAR;
            clr_d      = '0;
            clearing_d = 1'b1;
          end else if (char_data == CH_BS) begin
            // Backing over a row boundary is just the previous linear cell.
            if (cur_addr != '0) begin
              cur_cmd     = CUR_BS;
              do_launch   = 1'b1;
              launch_addr = cur_addr - 1'b1;
              adv_d       = 1'b0;
            end
          end else if (is_printable(char_data)) begin
            do_launch   = 1'b1;
            launch_addr = cur_addr;
            launch_chr  = char_data;
            adv_d       = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (!ACK) begin
          do_launch   = 1'b1;
          launch_addr = clr_q;
          adv_d       = 1'b0;
        end
      end
      S_WRITE: begin
        if (ACK) begin
          stb_d   = 1'b0;
          state_d = S_RELEASE;
          tmo_d   = '0;
          if (adv_q) cur_cmd = CUR_ADV;
          adv_d   = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!ACK) begin
          tmo_d = '0;
          if (!clearing_q) begin
            state_d = S_IDLE;
          end else if (clr_q == LAST_CELL) begin
            clearing_d = 1'b0;
            state_d    = S_IDLE;
            cur_cmd    = CUR_HOME;
          end else begin
            // Chain straight into the next cell to keep the clear at 4 cycles per cell.
            clr_d       = clr_q + 1'b1;
            do_launch   = 1'b1;
            launch_addr = clr_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      stb_d   = 1'b0;
      err_d   = 1'b1;
      state_d = S_IDLE;
      tmo_d   = '0;
      if (clearing_q) begin
        clearing_d = 1'b0;
        cur_cmd    = CUR_HOME;
      end else if (adv_q) begin
        cur_cmd = CUR_ADV;
        adv_d   = 1'b0;
      end
    end

    if (do_launch) begin
      state_d = S_WRITE;
      stb_d   = 1'b1;
      addr_d  = launch_addr;
      dat_d   = {ATTR, launch_chr};
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RESET_STATE;
      stb_q      <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      clearing_q <= CLEAR_ON_RESET;
      adv_q      <= 1'b0;
      clr_q      <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      clearing_q <= clearing_d;
      adv_q      <= adv_d;
      clr_q      <= clr_d;
    end
  end

  assign STB   = stb_q;
  assign ADDR  = {{(32 - ADDR_W){1'b0}}, addr_q};
  assign DAT_O = {16'h0000, dat_q};
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Bus initiator that drives the video card's character-buffer write port (STB/ACK, ADDR, DAT).
- Accepts a byte stream of characters over a valid/ready handshake and keeps a text cursor.
- Interprets control codes and turns each printable character into one bus write of {attribute, ASCII} at cell y*COLS+x.
- Sits between the CPU/UART byte source and the video card, so software never computes buffer addresses.

Parameters:
- COLS, 80: characters per row.
- ROWS, 60: rows per screen; COLS*ROWS = 4800 cells.
- ATTR, 8'h00: attribute byte placed in DAT_O[15:8]. Reserved by the video card, which ignores it.
- ACK_TIMEOUT, 64: maximum cycles spent waiting for an ACK edge before the write is abandoned.
- CLEAR_ON_RESET, 1: when 1, a full-screen clear runs automatically after reset release.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- char_valid  in  1  source presents char_data.
- char_data  in  8  ASCII byte.
- char_ready  out  1  block accepts a byte this cycle.
- clear_req  in  1  request a full-screen clear; level, sampled in IDLE.
- busy  out  1  high whenever state != IDLE.
- err  out  1  sticky ACK-timeout flag.
- cursor_x  out  7  current column, 0..COLS-1.
- cursor_y  out  6  current row, 0..ROWS-1.
- STB  out  1  write strobe to the video card.
- ADDR  out  32  cell index, zero-extended.
- DAT_O  out  32  {16'h0, ATTR, char}.
- ACK  in  1  write acknowledge from the video card.

Behaviour:
- Reset (reset=0, asynchronous):
  - STB=0, ADDR=0, DAT_O=0, cursor=(0,0), err=0, timeout counter=0.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
- States: IDLE, WRITE, RELEASE, CLEAR.
- IDLE:
  - char_ready=1 only in IDLE with clear_req=0.
  - clear_req has priority over char_valid: go to CLEAR with clear counter=0 and err cleared.
  - A byte is accepted on the cycle char_valid & char_ready. It is decoded combinationally and registered as follows.
- Control and printable bytes:
  - 0x0A (LF): x=0; y=y+1, wrapping ROWS-1→0. No bus write; stays IDLE.
  - 0x0D (CR): x=0. No write.
  - 0x0C (FF): enter CLEAR; cursor ends at (0,0).
  - 0x08 (BS) at x>0: cursor to x-1, then write 0x20 there.
  - 0x08 (BS) at x==0, y>0: cursor to (COLS-1, y-1), then write 0x20.
  - 0x08 (BS) at (0,0): ignored.
  - 0x20..0x7E and 0x80..0xFF: write char at the current cell, then advance. At x==COLS-1, x=0 and y=y+1 (wrap ROWS-1→0). There is no scrolling.
  - Other bytes below 0x20 and 0x7F: discarded, no write.
- WRITE:
  - ADDR, DAT_O and STB=1 are registered on entry.
  - STB, ADDR and DAT_O are held stable until ACK=1 is sampled.
  - On the next cycle STB=0 and state goes to RELEASE. The cursor advance for a printable char is applied on this transition.
- RELEASE:
  - STB=0; wait for ACK=0, because the video card's ACK is registered and lags STB by one cycle.
  - Then go to IDLE, or to the next cell if in a clear sequence.
  - A new STB is never raised while ACK=1.
- Timeout:
  - A counter runs in WRITE and RELEASE and resets on every state change.
  - Reaching ACK_TIMEOUT sets err=1, forces STB=0, still applies the cursor advance, and returns to IDLE.
  - A timeout during CLEAR aborts the clear; the cursor goes to (0,0).
- CLEAR:
  - Sequentially writes {ATTR, 0x20} to cells 0..COLS*ROWS-1 using the same WRITE/RELEASE handshake.
  - After the last cell: cursor=(0,0), state IDLE.
  - char_valid and clear_req are ignored while the clear runs.
- Timing against the video card (ACK registered one cycle after STB):
  - Accept at cycle 0; STB=1 in cycles 1-2; STB=0 from cycle 3; ACK=0 at cycle 4; char_ready=1 at cycle 5.
  - A full clear is therefore 4 cycles/cell × 4800 = 19200 cycles (±2).
- Arithmetic:
  - addr = y*COLS + x, 13-bit unsigned, zero-extended to 32 bits.
  - No partial-width truncation is allowed.
- Reset asserted mid-write: STB drops asynchronously and the in-flight write is abandoned. The slave may or may not have latched it; this is acceptable.

Decomposition:
- Shared package text_console_pkg holds:
  - COLS and ROWS defaults;
  - control-code constants (LF, CR, FF, BS, SPACE);
  - the state enum;
  - the cell-address width (13).
- One sub-module, text_cursor, holds:
  - x/y registers with advance, newline, backspace and home commands;
  - the combinational address output y*COLS+x.

Test Plan:
- Reset with CLEAR_ON_RESET=1, slave model = video card:
  - exactly 4800 writes of DAT=0x0020 to ADDR 0..4799 in order;
  - then busy=0, char_ready=1, cursor=(0,0).
- Send "Hi":
  - writes (ADDR 0, DAT 0x0048) and (ADDR 1, DAT 0x0069);
  - cursor=(2,0); char_ready returns 5 cycles after each accept.
- Cursor at (79,0), send 'A':
  - write ADDR 79, DAT 0x0041; cursor=(0,1).
  - At (79,59), 'A' gives ADDR 4799 and cursor=(0,0).
- Control codes:
  - LF at (5,3) → (0,4), no STB.
  - BS at (0,4) → (79,3) plus write 0x0020 to ADDR 319.
  - BS at (0,0) → no STB.
- Slave never acks:
  - STB held 64 cycles, then dropped;
  - err=1 and cursor advanced by one;
  - the next clear_req clears err.
- clear_req and char_valid high in the same IDLE cycle:
  - the clear is taken and the char is not accepted;
  - reset pulsed mid-clear → STB=0 immediately, and the clear restarts after release.
